// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample tick positions
// and the mid-bit majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

    localparam int SAMPLE_A  = 7;
    localparam int SAMPLE_B  = 8;
    localparam int SAMPLE_C  = 9;
    localparam int LAST_TICK = 15;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, with a selectable
// rising- or falling-edge pulse derived from the synchronised level.
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   FALL_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic edge_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign edge_o  = FALL_EDGE ? (prev_q & ~sync_q) : (sync_q & ~prev_q);

endmodule

// File: rtl/uart_rx_16x.sv
// 16x oversampling UART receiver: majority-voted mid-bit samples, optional
// parity, one-cycle strobes for good data, framing and parity errors.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk50MHz,
    input  logic                 reset,
    input  logic                 baudClk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    logic rxd_s, rxd_fall, tick, unused_baud_lvl;

    sync_edge_det #(.RESET_VAL(1'b1), .FALL_EDGE(1'b1)) u_rxd_sync (
        .clk_i(clk50MHz), .rst_i(reset), .d_i(rxd),
        .level_o(rxd_s), .edge_o(rxd_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b0), .FALL_EDGE(1'b0)) u_baud_sync (
        .clk_i(clk50MHz), .rst_i(reset), .d_i(baudClk),
        .level_o(unused_baud_lvl), .edge_o(tick)
    );

    uart_rx_state_t       state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [2:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q, rx_data_q;
    logic                 par_bit_q, armed_q, busy_q;
    logic                 rx_valid_q, frame_err_q, parity_err_q;

    logic [TW-1:0] tick_pos_d;
    logic          vote_d, stop_vote_d, par_bad_d, bit_end_d;

    // tick_pos_d is the position of the tick arriving this cycle; the start edge was position 0.
    assign tick_pos_d  = (tick_cnt_q == TW'(LAST_TICK)) ? '0 : tick_cnt_q + 1'b1;
    assign bit_end_d   = tick && (tick_pos_d == TW'(LAST_TICK));
    assign vote_d      = maj3(samp_q);
    // The stop bit is decided on its third sample, so that sample comes straight off the line.
    assign stop_vote_d = maj3({rxd_s, samp_q[1:0]});
    assign par_bad_d   = (PARITY_EN != 0) &&
                         (par_bit_q != ((^shift_q) ^ (PARITY_ODD != 0)));

    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            par_bit_q    <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;

            if (tick && state_q != ST_IDLE) begin
                tick_cnt_q <= tick_pos_d;
                if (tick_pos_d == TW'(SAMPLE_A)) samp_q[0] <= rxd_s;
                if (tick_pos_d == TW'(SAMPLE_B)) samp_q[1] <= rxd_s;
                if (tick_pos_d == TW'(SAMPLE_C)) samp_q[2] <= rxd_s;
            end

            case (state_q)
                ST_IDLE: begin
                    // A line that stayed low through the stop bit must go high before re-arming.
                    if (rxd_s) armed_q <= 1'b1;
                    if (armed_q && rxd_fall) begin
                        state_q    <= ST_START;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_START: if (bit_end_d) begin
                    if (vote_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: if (bit_end_d) begin
                    shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS-1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: if (bit_end_d) begin
                    par_bit_q <= vote_d;
                    state_q   <= ST_STOP;
                end
                ST_STOP: if (tick && tick_pos_d == TW'(SAMPLE_C)) begin
                    rx_data_q <= shift_q;
                    if (!stop_vote_d)   frame_err_q  <= 1'b1;
                    else if (par_bad_d) parity_err_q <= 1'b1;
                    else                rx_valid_q   <= 1'b1;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    armed_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rxData    = rx_data_q;
    assign rxValid   = rx_valid_q;
    assign frameErr  = frame_err_q;
    assign parityErr = parity_err_q;
    assign busy      = busy_q;

endmodule
